conv2d_window_buffer: RTL and testbench
=======================================

# conv2d_window_buffer

Streaming 3x3 window generator that sits directly upstream of the parameterized 3x3 convolution sum stage. It accepts one signed pixel per cycle in raster order and buffers two image lines. It emits one zero-padded 3x3 window per output pixel ("same" convolution, H×W windows per frame) in exactly the `[row][col]` layout the sum stage consumes as its `zeroedMatrix` input. After the last input pixel it flushes the final row and column internally without further input.

## Interface
- `bitWidth`, 16, pixel/word width (signed, passed through unchanged)
- `imgWidth`, 28, pixels per image row W (≥2)
- `imgHeight`, 28, rows per frame H (≥2)
- Filter dimension is fixed at 3; not a parameter.

Ports:
- `clock`  in  1  sole clock, all state on posedge
- `reset`  in  1  synchronous, active-high
- `pixel_in`  in  bitWidth  signed input pixel
- `pixel_valid`  in  1  `pixel_in` presented this cycle
- `in_ready`  out  1  block accepts a pixel this cycle
- `window`  out  bitWidth × [3][3]  signed window, `[0][*]` = row above centre, `[*][0]` = column left of centre
- `win_valid`  out  1  `window` valid this cycle
- `frame_done`  out  1  one-cycle pulse coincident with the last window of a frame
- `win_row`  out  $clog2(imgHeight)  centre row of `window` (only with `CONV_WINDOW_COORD_EN`)
- `win_col`  out  $clog2(imgWidth)  centre column of `window` (only with `CONV_WINDOW_COORD_EN`)

## Operation
- Position counter `p` counts stream positions `0 .. W*H+W`.
  - Positions `< W*H` are real pixels, taken on `pixel_valid && in_ready`.
  - Positions `W*H .. W*H+W` (W+1 of them) are flush positions carrying virtual zero pixels.
- Storage: two W-deep line buffers (shift registers or RAM) plus a 3x3 register window. Each processed position shifts the window one column and advances the line buffers.
- Processing position `p ≥ W+1` produces the window centred at linear index `c = p-W-1`, with `orow = c / W` and `ocol = c % W` (tracked with row/col counters, no divider).
- Zero padding is applied by masking on the output register:
  - row 0 of the window is zero when `orow==0`;
  - row 2 is zero when `orow==H-1`;
  - column 0 is zero when `ocol==0`;
  - column 2 is zero when `ocol==W-1`.
  - Masking alone guarantees stale line-buffer or window contents never reach `window`, so line buffers need no clearing.
- State machine:
  - FILL: `in_ready=1`, no output. Advances to RUN after accepting position W (the (W+1)th pixel).
  - RUN: `in_ready=1`, one window per accepted pixel. Advances to FLUSH after accepting position W*H-1.
  - FLUSH: `in_ready=0`, processes one virtual position per cycle unconditionally. After position W*H+W it returns to FILL with all counters at 0.
- If `pixel_valid=0` in FILL/RUN: nothing shifts, no window is emitted, and state holds.
- Data is passed through bit-exact; no arithmetic is performed on pixel values.

## Timing
- Reset values:
  - `in_ready=0` during the reset cycle, 1 the cycle after;
  - `win_valid=0`, `frame_done=0`, `window` all zero;
  - `win_row`/`win_col` = 0;
  - state FILL, `p=0`.
- Latency: a window is registered and `win_valid` is high one cycle after the position that completes it is processed.
- Throughput: one window per cycle while fed continuously. Frame period is W*H + W+1 cycles minimum.
- `frame_done` is high in the same cycle as `win_valid` for centre (H-1, W-1).
- Reset asserted mid-frame (including during FLUSH) aborts the frame:
  - no further windows are emitted;
  - the next cycle begins a new frame in FILL.
- A pixel presented while `in_ready=0` is not consumed; the source must hold it.
- Back-to-back frames: the first pixel of the next frame is accepted the cycle after the last flush position.

## Configuration
- `CONV_WINDOW_COORD_EN` defined: `win_row` and `win_col` ports exist and are registered alongside `window`. They are valid when `win_valid=1` and hold their last value otherwise.
- Undefined: the ports and their counters are absent. All other behaviour is identical.

## Test plan
All scenarios use W=H=4, pixels 1..16 in raster order, fed continuously.
- Reset, then feed the pixels → first `win_valid` the cycle after accepting pixel 6; window = [[0,0,0],[0,1,2],[0,5,6]], centre (0,0).
- Same stream → window at centre (1,1) = [[1,2,3],[5,6,7],[9,10,11]]; centre (1,3) = [[3,4,0],[7,8,0],[11,12,0]].
- After pixel 16 is accepted → `in_ready` low for exactly 5 cycles. Last window, centre (3,3), = [[11,12,0],[15,16,0],[0,0,0]] with `frame_done=1`. Exactly 16 windows total.
- Random `pixel_valid` gaps (≈50%) → same 16 windows in the same order, none emitted in gap cycles.
- Assert `reset` for 1 cycle after pixel 9 → no windows until 6 new pixels are accepted. A new frame of values 101..116 yields centre (0,0) = [[0,0,0],[0,101,102],[0,105,106]], with no stale data.
- Two frames back-to-back with pixels held valid during flush → no pixel lost; the second frame's windows match the first-frame checks offset by +100.

Source files
------------

// File: rtl/conv2d_window_buffer.sv
// Streaming 3x3 zero-padded window generator ("same" conv) fed one pixel per cycle in raster order.
// Optional macro CONV_WINDOW_COORD_EN adds registered win_row/win_col centre coordinates.
module conv2d_window_buffer #(
   parameter int bitWidth  = 16,
   parameter int imgWidth  = 28,
   parameter int imgHeight = 28
) (
   input  logic                                 clock,
   input  logic                                 reset,
   input  logic signed [bitWidth-1:0]           pixel_in,
   input  logic                                 pixel_valid,
   output logic                                 in_ready,
   output logic signed [2:0][2:0][bitWidth-1:0] window,
   output logic                                 win_valid,
   output logic                                 frame_done
`ifdef CONV_WINDOW_COORD_EN
   ,
   output logic [$clog2(imgHeight)-1:0]         win_row,
   output logic [$clog2(imgWidth)-1:0]          win_col
`endif
);
   localparam int RW   = $clog2(imgHeight);
   localparam int CW   = $clog2(imgWidth);
   localparam int NPIX = imgWidth * imgHeight;
   localparam int PW   = $clog2(NPIX + imgWidth + 1);
   localparam logic [PW-1:0] P_FILL_LAST  = PW'(imgWidth);
   localparam logic [PW-1:0] P_RUN_LAST   = PW'(NPIX - 1);
   localparam logic [PW-1:0] P_FLUSH_LAST = PW'(NPIX + imgWidth);
   localparam logic [RW-1:0] ROW_LAST     = RW'(imgHeight - 1);
   localparam logic [CW-1:0] COL_LAST     = CW'(imgWidth - 1);

   typedef enum logic [1:0] {FILL, RUN, FLUSH} state_t;
   typedef logic [2:0][2:0][bitWidth-1:0] win_t;

   state_t                            state_q, state_d;
   logic [PW-1:0]                     p_q, p_d;
   logic [RW-1:0]                     orow_q, orow_d;
   logic [CW-1:0]                     ocol_q, ocol_d;
   logic [imgWidth-1:0][bitWidth-1:0] lb0_q, lb0_d, lb1_q, lb1_d;
   win_t                              win_q, win_d, window_q, window_d;
   logic                              win_valid_q, win_valid_d;
   logic                              frame_done_q, frame_done_d;
   logic                              step;
   logic [bitWidth-1:0]               x;
`ifdef CONV_WINDOW_COORD_EN
   logic [RW-1:0]                     win_row_q, win_row_d;
   logic [CW-1:0]                     win_col_q, win_col_d;
`endif

   // Gated by reset so the source sees not-ready during the reset cycle itself.
   assign in_ready   = !reset && (state_q != FLUSH);
   assign window     = window_q;
   assign win_valid  = win_valid_q;
   assign frame_done = frame_done_q;
`ifdef CONV_WINDOW_COORD_EN
   assign win_row    = win_row_q;
   assign win_col    = win_col_q;
`endif

   always_comb begin
      state_d      = state_q;
      p_d          = p_q;
      orow_d       = orow_q;
      ocol_d       = ocol_q;
      lb0_d        = lb0_q;
      lb1_d        = lb1_q;
      win_d        = win_q;
      window_d     = window_q;
      win_valid_d  = 1'b0;
      frame_done_d = 1'b0;
`ifdef CONV_WINDOW_COORD_EN
      win_row_d    = win_row_q;
      win_col_d    = win_col_q;
`endif
      step = (state_q == FLUSH) || (pixel_valid && in_ready);
      x    = (state_q == FLUSH) ? '0 : pixel_in;

      if (step) begin
         // Line-buffer tails hold pixels p-W and p-2W: the new right column of the window.
         lb0_d = {lb0_q[imgWidth-2:0], x};
         lb1_d = {lb1_q[imgWidth-2:0], lb0_q[imgWidth-1]};
         for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
         end
         win_d[0][2] = lb1_q[imgWidth-1];
         win_d[1][2] = lb0_q[imgWidth-1];
         win_d[2][2] = x;
         p_d = p_q + PW'(1);

         if (state_q != FILL) begin
            for (int r = 0; r < 3; r++)
               for (int c = 0; c < 3; c++)
                  window_d[r][c] = ((r == 0 && orow_q == '0) || (r == 2 && orow_q == ROW_LAST) ||
                                    (c == 0 && ocol_q == '0) || (c == 2 && ocol_q == COL_LAST))
                                   ? '0 : win_d[r][c];
            win_valid_d  = 1'b1;
            frame_done_d = (orow_q == ROW_LAST) && (ocol_q == COL_LAST);
`ifdef CONV_WINDOW_COORD_EN
            win_row_d    = orow_q;
            win_col_d    = ocol_q;
`endif
            if (ocol_q == COL_LAST) begin
               ocol_d = '0;
               orow_d = orow_q + RW'(1);
            end else begin
               ocol_d = ocol_q + CW'(1);
            end
         end

         case (state_q)
            FILL:    if (p_q == P_FILL_LAST) state_d = RUN;
            RUN:     if (p_q == P_RUN_LAST) state_d = FLUSH;
            FLUSH:   if (p_q == P_FLUSH_LAST) begin
                        state_d = FILL;
                        p_d     = '0;
                        orow_d  = '0;
                        ocol_d  = '0;
                     end
            default: state_d = FILL;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q      <= FILL;
         p_q          <= '0;
         orow_q       <= '0;
         ocol_q       <= '0;
         window_q     <= '0;
         win_valid_q  <= 1'b0;
         frame_done_q <= 1'b0;
`ifdef CONV_WINDOW_COORD_EN
         win_row_q    <= '0;
         win_col_q    <= '0;
`endif
      end else begin
         state_q      <= state_d;
         p_q          <= p_d;
         orow_q       <= orow_d;
         ocol_q       <= ocol_d;
         window_q     <= window_d;
         win_valid_q  <= win_valid_d;
         frame_done_q <= frame_done_d;
`ifdef CONV_WINDOW_COORD_EN
         win_row_q    <= win_row_d;
         win_col_q    <= win_col_d;
`endif
      end
   end

   // Stale contents are masked at the output, so the data path needs no reset.
   always_ff @(posedge clock) begin
      lb0_q <= lb0_d;
      lb1_q <= lb1_d;
      win_q <= win_d;
   end
endmodule

// File: tb/tb_conv2d_window_buffer.sv
// Bench for conv2d_window_buffer at W=H=4: image-level window model plus literal spot checks.
module tb_conv2d_window_buffer;
   localparam int W = 4;
   localparam int H = 4;
   typedef logic [2:0][2:0][15:0] win_t;

   logic                       clock = 1'b0;
   logic                       reset = 1'b1;
   logic signed [15:0]         pixel_in = '0;
   logic                       pixel_valid = 1'b0;
   logic                       in_ready;
   logic signed [2:0][2:0][15:0] window;
   logic                       win_valid;
   logic                       frame_done;
`ifdef CONV_WINDOW_COORD_EN
   logic [1:0]                 win_row, win_col;
`endif

   conv2d_window_buffer #(.bitWidth(16), .imgWidth(W), .imgHeight(H)) dut (
      .clock(clock), .reset(reset), .pixel_in(pixel_in), .pixel_valid(pixel_valid),
      .in_ready(in_ready), .window(window), .win_valid(win_valid), .frame_done(frame_done)
`ifdef CONV_WINDOW_COORD_EN
      , .win_row(win_row), .win_col(win_col)
`endif
   );

   always #5 clock = ~clock;

   int   n_cmp = 0;
   int   n_fail = 0;
   int   bq[$];          // pixel base of each frame whose windows are still expected
   int   widx = 0;
   int   nacc = 0;
   int   nwin = 0;
   int   lowrun = 0;
   bit   acc_prev = 0, flush_prev = 0;
   win_t got[int];

   task automatic chk(input string name, input logic [143:0] act, input logic [143:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Pixel (r,c) of a frame is base + r*W + c + 1; outside the image it is zero padding.
   function automatic win_t exp_window(input int base, input int r, input int c);
      win_t w;
      for (int i = 0; i < 3; i++)
         for (int j = 0; j < 3; j++) begin
            int rr, cc;
            rr = r + i - 1;
            cc = c + j - 1;
            w[i][j] = (rr >= 0 && rr < H && cc >= 0 && cc < W) ? 16'(base + rr * W + cc + 1) : 16'h0;
         end
      return w;
   endfunction

   function automatic win_t w9(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
      win_t w;
      w[0][0] = 16'(a0); w[0][1] = 16'(a1); w[0][2] = 16'(a2);
      w[1][0] = 16'(a3); w[1][1] = 16'(a4); w[1][2] = 16'(a5);
      w[2][0] = 16'(a6); w[2][1] = 16'(a7); w[2][2] = 16'(a8);
      return w;
   endfunction

   // Compare process: every window against the model, in order, and never in an idle cycle.
   always @(negedge clock) begin
      if (win_valid) begin
         chk("window_has_cause", acc_prev || flush_prev, 1'b1);
         chk("window_expected", bq.size() != 0, 1'b1);
         if (bq.size() != 0) begin
            chk("window", window, exp_window(bq[0], widx / W, widx % W));
            chk("frame_done", frame_done, widx == W * H - 1);
`ifdef CONV_WINDOW_COORD_EN
            chk("win_row", win_row, 2'(widx / W));
            chk("win_col", win_col, 2'(widx % W));
`endif
            if (widx == 0) chk("first_win_latency", nacc, 6);
            got[bq[0] * 100 + widx] = window;
            nwin++;
            if (widx == W * H - 1) begin
               widx = 0;
               nacc = 0;
               void'(bq.pop_front());
            end else widx++;
         end
      end else if (frame_done) begin
         chk("frame_done_without_window", frame_done, 1'b0);
      end
      if (reset) begin
         widx = 0; nacc = 0; lowrun = 0;
         acc_prev = 0; flush_prev = 0;
         if (bq.size() != 0) void'(bq.pop_front());
      end else begin
         acc_prev   = pixel_valid && in_ready;
         flush_prev = !in_ready;
         if (acc_prev) nacc++;
         if (!in_ready) lowrun++;
         else if (lowrun > 0) begin
            chk("flush_len", lowrun, W + 1);
            lowrun = 0;
         end
      end
   end

   task automatic feed(input int base, input int first, input int last, input bit gaps);
      int i = first;
      int budget = 0;
      bit acc;
      while (i <= last) begin
         if (budget > 400) begin
            n_cmp++; n_fail++;
            $display("FAIL feed_timeout: got pixel %0d expected %0d", i, last);
            break;
         end
         pixel_valid = gaps ? ($urandom_range(1) == 1) : 1'b1;
         pixel_in    = pixel_valid ? 16'(base + i) : 16'($urandom);
         @(negedge clock);
         acc = pixel_valid && in_ready;
         @(posedge clock); #1;
         if (acc) i++;
         budget++;
      end
      pixel_valid = 1'b0;
   endtask

   task automatic feed_frame(input int base, input bit gaps);
      bq.push_back(base);
      feed(base, 1, W * H, gaps);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((bq.size() != 0 || !in_ready) && n < 300) begin
         @(posedge clock); #1;
         n++;
      end
      chk("idle_timeout", n < 300, 1'b1);
   endtask

   task automatic chk_got(input string name, input int key, input win_t exp);
      chk({name, "_present"}, got.exists(key), 1'b1);
      if (got.exists(key)) chk(name, got[key], exp);
   endtask

   initial begin
      int n0;
      // Model pinned against hand-computed windows.
      chk("model_c00", exp_window(0, 0, 0), w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk("model_c13", exp_window(0, 1, 3), w9(3, 4, 0, 7, 8, 0, 11, 12, 0));

      repeat (2) @(posedge clock);
      @(negedge clock);
      chk("rst_in_ready", in_ready, 1'b0);
      chk("rst_win_valid", win_valid, 1'b0);
      chk("rst_frame_done", frame_done, 1'b0);
      chk("rst_window", window, '0);
`ifdef CONV_WINDOW_COORD_EN
      chk("rst_coord", {win_row, win_col}, 4'h0);
`endif
      @(posedge clock); #1;
      reset = 1'b0;
      @(negedge clock);
      chk("in_ready_after_rst", in_ready, 1'b1);
      @(posedge clock); #1;

      // Continuous frame.
      n0 = nwin;
      feed_frame(0, 0);
      wait_idle();
      chk("count_cont", nwin - n0, 16);
      chk_got("c00", 0, w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk_got("c11", 5, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk_got("c13", 7, w9(3, 4, 0, 7, 8, 0, 11, 12, 0));
      chk_got("c33", 15, w9(11, 12, 0, 15, 16, 0, 0, 0, 0));

      // Random valid gaps.
      got.delete();
      n0 = nwin;
      feed_frame(0, 1);
      wait_idle();
      chk("count_gaps", nwin - n0, 16);
      chk_got("gap_c00", 0, w9(0, 0, 0, 0, 1, 2, 0, 5, 6));
      chk_got("gap_c33", 15, w9(11, 12, 0, 15, 16, 0, 0, 0, 0));

      // Abort mid-frame after pixel 9, then a fresh frame.
      got.delete();
      bq.push_back(0);
      feed(0, 1, 9, 0);
      reset = 1'b1;
      @(posedge clock); #1;
      reset = 1'b0;
      n0 = nwin;
      feed_frame(100, 0);
      wait_idle();
      chk("count_after_abort", nwin - n0, 16);
      chk_got("abort_c00", 10000, w9(0, 0, 0, 0, 101, 102, 0, 105, 106));

      // Back-to-back frames, second pixel stream held valid through flush.
      got.delete();
      n0 = nwin;
      feed_frame(0, 0);
      feed_frame(100, 0);
      wait_idle();
      chk("count_b2b", nwin - n0, 32);
      chk_got("b2b_a_c11", 5, w9(1, 2, 3, 5, 6, 7, 9, 10, 11));
      chk_got("b2b_c00", 10000, w9(0, 0, 0, 0, 101, 102, 0, 105, 106));
      chk_got("b2b_c11", 10005, w9(101, 102, 103, 105, 106, 107, 109, 110, 111));
      chk_got("b2b_c13", 10007, w9(103, 104, 0, 107, 108, 0, 111, 112, 0));
      chk_got("b2b_c33", 10015, w9(111, 112, 0, 115, 116, 0, 0, 0, 0));

      repeat (3) @(posedge clock);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
